// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared line geometry, FSM states and memory read-port widths
package inst_cache_pkg;

    localparam int LINE_OFF_BITS = 4;
    localparam int LINE_WORDS    = 4;
    localparam int WORD_SEL_BITS = 2;
    localparam int MEM_ADDR_W    = 32;
    localparam int MEM_DATA_W    = 32;
    localparam int LINE_ADDR_W   = MEM_ADDR_W - LINE_OFF_BITS;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    typedef logic [MEM_DATA_W-1:0] word_t;
    typedef logic [LINE_WORDS-1:0][MEM_DATA_W-1:0] line_t;

    function automatic logic [15:0] sel_half(input word_t w, input logic upper);
        return upper ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// rtl/inst_cache_if.sv - fetch-side and memory-read-side signals of the instruction cache
interface inst_cache_if;
    import inst_cache_pkg::*;

    logic                  fetch_ready_in;
    logic [31:0]           fetch_pc;
    logic [31:0]           inst_out;
    logic                  inst_ready_out;
    logic                  mem_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [MEM_DATA_W-1:0] mem_data;
    logic                  mem_done;

    modport slave (
        input  fetch_ready_in, fetch_pc, mem_data, mem_done,
        output inst_out, inst_ready_out, mem_req, mem_addr
    );

    modport master (
        output fetch_ready_in, fetch_pc, mem_data, mem_done,
        input  inst_out, inst_ready_out, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage: full-line read port A, word-0 read port B, one word write port
module icache_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = LINE_ADDR_W - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] a_idx,
    output logic                  a_valid,
    output logic [TAG_BITS-1:0]   a_tag,
    output line_t                 a_line,
    input  logic [INDEX_BITS-1:0] b_idx,
    output logic                  b_valid,
    output logic [TAG_BITS-1:0]   b_tag,
    output word_t                 b_word0,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [WORD_SEL_BITS-1:0] wr_word,
    input  word_t                 wr_data,
    input  logic                  fill_done,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic                  inval_en,
    input  logic [INDEX_BITS-1:0] inval_idx
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [TAG_BITS-1:0] tag_d [LINES];
    line_t               data_q [LINES];
    line_t               data_d [LINES];

    assign a_valid = valid_q[a_idx];
    assign a_tag   = tag_q[a_idx];
    assign a_line  = data_q[a_idx];
    assign b_valid = valid_q[b_idx];
    assign b_tag   = tag_q[b_idx];
    assign b_word0 = data_q[b_idx][0];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inval_en) begin
            valid_d[inval_idx] = 1'b0;
        end
        if (wr_en) begin
            data_d[wr_idx][wr_word] = wr_data;
        end
        // The line only becomes valid together with its last word and tag.
        if (fill_done) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with halfword-granular fetch
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clear,
    inst_cache_if.slave   bus
);

    localparam int TAG_BITS = LINE_ADDR_W - INDEX_BITS;

    logic [31:0]            pc;
    logic [LINE_ADDR_W-1:0] line_a, line_b;
    logic [INDEX_BITS-1:0]  idx_a, idx_b;
    logic                   a_valid, b_valid, hit_a, hit_b;
    logic [TAG_BITS-1:0]    a_tag, b_tag;
    line_t                  a_line;
    word_t                  b_word0, lo_word;
    logic [WORD_SEL_BITS-1:0] word_sel, nxt_sel;
    logic                   straddle, compressed, ready;
    logic [15:0]            lo, hi;
    logic                   unused_pc0;

    state_t                 state_q, state_d;
    logic [WORD_SEL_BITS-1:0] cnt_q, cnt_d;
    logic                   abort_q, abort_d, abort_eff;
    logic [LINE_ADDR_W-1:0] base_q, base_d;
    logic                   mem_req, wr_en, fill_done, inval_en;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [INDEX_BITS-1:0]  inval_idx;

    assign pc         = bus.fetch_pc;
    assign unused_pc0 = pc[0];
    assign line_a     = pc[31:LINE_OFF_BITS];
    assign line_b     = line_a + 1'b1;
    assign idx_a      = line_a[INDEX_BITS-1:0];
    assign idx_b      = line_b[INDEX_BITS-1:0];

    icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk       (clk),
        .rst       (rst),
        .a_idx     (idx_a),
        .a_valid   (a_valid),
        .a_tag     (a_tag),
        .a_line    (a_line),
        .b_idx     (idx_b),
        .b_valid   (b_valid),
        .b_tag     (b_tag),
        .b_word0   (b_word0),
        .wr_en     (wr_en),
        .wr_idx    (base_q[INDEX_BITS-1:0]),
        .wr_word   (cnt_q),
        .wr_data   (bus.mem_data),
        .fill_done (fill_done),
        .fill_tag  (base_q[LINE_ADDR_W-1:INDEX_BITS]),
        .inval_en  (inval_en),
        .inval_idx (inval_idx)
    );

    assign hit_a      = a_valid && (a_tag == line_a[LINE_ADDR_W-1:INDEX_BITS]);
    assign hit_b      = b_valid && (b_tag == line_b[LINE_ADDR_W-1:INDEX_BITS]);
    assign word_sel   = pc[3:2];
    assign nxt_sel    = word_sel + 2'd1;
    assign straddle   = &pc[3:1];
    assign lo_word    = a_line[word_sel];
    assign lo         = sel_half(lo_word, pc[1]);
    assign compressed = (lo[1:0] != 2'b11);

    // A compressed halfword at the line end is deliverable without line B; its upper half reads 0.
    always_comb begin
        hi = '0;
        if (!pc[1]) begin
            hi = lo_word[31:16];
        end else if (!straddle) begin
            hi = a_line[nxt_sel][15:0];
        end else if (hit_b) begin
            hi = b_word0[15:0];
        end
    end

    assign ready = rdy && bus.fetch_ready_in && (state_q == IDLE) && hit_a
                   && (!straddle || hit_b || compressed);

    assign bus.inst_ready_out = ready;
    assign bus.inst_out       = ready ? {hi, lo} : 32'h0;
    assign bus.mem_req        = mem_req;
    assign bus.mem_addr       = mem_addr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        base_d    = base_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        wr_en     = 1'b0;
        fill_done = 1'b0;
        inval_en  = 1'b0;
        inval_idx = hit_a ? idx_b : idx_a;
        abort_eff = abort_q || clear;
        case (state_q)
            IDLE: begin
                if (rdy && bus.fetch_ready_in && !ready && !clear) begin
                    base_d   = hit_a ? line_b : line_a;
                    inval_en = 1'b1;
                    cnt_d    = '0;
                    abort_d  = 1'b0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {base_q, cnt_q, 2'b00};
                // An aborted fill still owns the outstanding word; it ends on that word's done.
                if (rdy) begin
                    abort_d = abort_eff;
                    if (bus.mem_done) begin
                        if (abort_eff) begin
                            state_d = IDLE;
                            abort_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
                                fill_done = 1'b1;
                                state_d   = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - directed self-checking bench for inst_cache with a word-latency memory responder
module tb_inst_cache;
    import inst_cache_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, clear;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   wait_ctr = 0;
    int   ready_cyc;
    int   base;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_log [$];

    inst_cache_if bus ();

    inst_cache #(.INDEX_BITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (addr_log.size() > i) ? addr_log[i] : 32'hFFFF_FFFF;
    endfunction

    // Memory controller: one wait cycle per word, frozen by rdy and reset by rst.
    initial begin
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_done = 1'b0;
                wait_ctr = 0;
            end else if (rdy) begin
                if (bus.mem_done) begin
                    bus.mem_done = 1'b0;
                    wait_ctr = 0;
                end else if (bus.mem_req) begin
                    if (wait_ctr == 1) begin
                        bus.mem_done = 1'b1;
                        bus.mem_data = mem_word(bus.mem_addr);
                        addr_log.push_back(bus.mem_addr);
                        done_cnt++;
                        last_done_cyc = cyc;
                    end else begin
                        wait_ctr++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        clear = 1'b0;
        bus.fetch_ready_in = 1'b0;
        bus.fetch_pc = '0;
        mem.delete();
        tick();
        tick();
        rst = 1'b0;
        addr_log.delete();
        done_cnt = 0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.inst_ready_out && n < 40) begin
            tick();
            n++;
        end
        ready_cyc = cyc;
        check(tag, {31'h0, bus.inst_ready_out}, 32'h1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'h0, done_cnt >= target}, 32'h1);
    endtask

    task automatic check_fill(input string tag, input logic [31:0] b);
        check({tag, "_len"}, addr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_at(i), b + 32'(4 * i));
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_pc = a;
        bus.fetch_ready_in = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_ready", {31'h0, bus.inst_ready_out}, 32'h0);
        check("rst_inst", bus.inst_out, 32'h0);
        check("rst_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);

        // Cold miss at 0x0, then a same-cycle hit at 0x4.
        mem[32'h0] = 32'h0000_0013; mem[32'h4] = 32'h0000_0093;
        mem[32'h8] = 32'h0000_0001; mem[32'hC] = 32'h0000_0002;
        fetch(32'h0);
        check("cold_not_ready", {31'h0, bus.inst_ready_out}, 32'h0);
        tick();
        check("cold_req_rise", {31'h0, bus.mem_req}, 32'h1);
        check("cold_first_addr", bus.mem_addr, 32'h0);
        wait_ready("cold_ready");
        check_fill("cold", 32'h0);
        check("cold_latency", ready_cyc, last_done_cyc + 1);
        check("cold_inst", bus.inst_out, 32'h0000_0013);
        check("cold_req_drop", {31'h0, bus.mem_req}, 32'h0);
        fetch(32'h4);
        check("hit4_ready", {31'h0, bus.inst_ready_out}, 32'h1);
        check("hit4_inst", bus.inst_out, 32'h0000_0093);

        // Intra-line unaligned access.
        do_reset();
        mem[32'h0] = 32'hBBBB_AAA3; mem[32'h4] = 32'hDDDD_CCCC;
        fetch(32'h0);
        wait_ready("unal_fill");
        check("unal_inst0", bus.inst_out, 32'hBBBB_AAA3);
        fetch(32'h2);
        check("unal_ready", {31'h0, bus.inst_ready_out}, 32'h1);
        check("unal_inst", bus.inst_out, 32'hCCCC_BBBB);
        tick();
        check("unal_no_req", {31'h0, bus.mem_req}, 32'h0);

        // Line straddle with line B absent: second fill of 0x10.
        do_reset();
        mem[32'hC] = 32'h4567_0001; mem[32'h10] = 32'h89AB_CDEF;
        fetch(32'h0);
        wait_ready("strad_fillA");
        addr_log.delete();
        fetch(32'hE);
        check("strad_not_ready", {31'h0, bus.inst_ready_out}, 32'h0);
        wait_ready("strad_ready");
        check_fill("strad", 32'h10);
        check("strad_inst", bus.inst_out, 32'hCDEF_4567);

        // Compressed halfword at the line boundary needs no line B.
        do_reset();
        mem[32'hC] = 32'h4001_0000; mem[32'h10] = 32'h89AB_CDEF;
        fetch(32'h0);
        wait_ready("comp_fillA");
        fetch(32'hE);
        check("comp_ready", {31'h0, bus.inst_ready_out}, 32'h1);
        check("comp_inst", bus.inst_out, 32'h0000_4001);
        tick();
        check("comp_no_req", {31'h0, bus.mem_req}, 32'h0);

        // Clear after the 2nd done: the 3rd word is still awaited, then the line stays invalid.
        do_reset();
        mem[32'h100] = 32'hC0C0_0100; mem[32'h104] = 32'hC0C0_0104;
        fetch(32'h100);
        wait_done(2, "clr_done2");
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_req_held", {31'h0, bus.mem_req}, 32'h1);
        for (int n = 0; n < 40 && bus.mem_req; n++) tick();
        check("clr_req_drop", {31'h0, bus.mem_req}, 32'h0);
        check("clr_done_cnt", done_cnt, 32'd3);
        check("clr_miss_again", {31'h0, bus.inst_ready_out}, 32'h0);
        addr_log.delete();
        wait_ready("clr_refill");
        check_fill("clr", 32'h100);
        check("clr_inst", bus.inst_out, 32'hC0C0_0100);

        // Conflict eviction at index 0, then a 3-cycle freeze mid-fill.
        do_reset();
        mem[32'h0] = 32'hA0A0_0000; mem[32'h100] = 32'hB0B0_0100;
        fetch(32'h0);
        wait_ready("conf_fill0");
        check("conf_inst0", bus.inst_out, 32'hA0A0_0000);
        fetch(32'h100);
        check("conf_miss100", {31'h0, bus.inst_ready_out}, 32'h0);
        wait_ready("conf_fill100");
        check("conf_inst100", bus.inst_out, 32'hB0B0_0100);
        fetch(32'h0);
        check("conf_evicted", {31'h0, bus.inst_ready_out}, 32'h0);
        addr_log.delete();
        base = done_cnt;
        wait_done(base + 1, "frz_done1");
        tick();
        rdy = 1'b0;
        #1;
        check("frz_addr0", bus.mem_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_addr", bus.mem_addr, 32'h4);
            check("frz_req", {31'h0, bus.mem_req}, 32'h1);
        end
        check("frz_done_cnt", done_cnt, base + 1);
        rdy = 1'b1;
        wait_ready("frz_ready");
        check_fill("frz", 32'h0);
        check("frz_inst", bus.inst_out, 32'hA0A0_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache serving the fetch stage. It answers a fetch PC that is 2-byte aligned with the 32 bits starting at that PC, same cycle on a hit. Any instruction or line-straddling halfword is assembled from two words or two lines. On a miss it fills 16-byte lines word by word from the memory controller.

## Interface
Parameters:
- INDEX_BITS, 4, line index width; 2^INDEX_BITS lines of 16 bytes (4 words)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush (branch mispredict); aborts an in-progress fill
- fetch_ready_in  in  1  fetch is requesting the instruction at fetch_pc
- fetch_pc  in  32  fetch address, bit 0 always 0
- inst_out  out  32  bytes fetch_pc+3..fetch_pc, little-endian; 0 when not ready
- inst_ready_out  out  1  inst_out is valid for the current fetch_pc (combinational)
- mem_req  out  1  word read request to memory controller
- mem_addr  out  32  word-aligned read address
- mem_data  in  32  read data, valid when mem_done
- mem_done  in  1  one-cycle pulse: current mem_addr word returned

## Operation
- Address split: offset = pc[3:0]; idx = pc[4+INDEX_BITS-1:4]; tag = pc[31:4+INDEX_BITS].
- Line A holds the line of pc. Line B holds the line of {pc[31:4]+1, 4'b0}; its index wraps modulo 2^INDEX_BITS.
- lo half = halfword at pc, from word pc[3:2] of line A.
- hi half = halfword at pc+2:
  - same word if pc[1]=0
  - word pc[3:2]+1 if pc[1]=1 and pc[3:2]≠3
  - word 0 of line B if pc[3:1]=3'b111 ("straddle")
- hit_A = valid and tag match for line A. hit_B = the same check for line B.
- inst_ready_out = rdy & fetch_ready_in & state==IDLE & hit_A & (!straddle | hit_B | lo[1:0]≠2'b11).
- A compressed lo half at a line boundary needs no line B. In that case, if line B is absent, inst_out[31:16]=0.
- FSM states are IDLE and FILL.
  - **IDLE:** if fetch_ready_in, not ready, and clear=0: fill_base = !hit_A ? line A base : line B base. Clear that line's valid, set cnt=0, go to FILL.
  - **FILL:** mem_req=1, mem_addr=fill_base+4·cnt. On mem_done, write mem_data into word cnt and increment cnt.
    - On the 4th done: write the tag, set valid, go to IDLE.
- The lookup repeats in IDLE, so a straddling miss on both lines takes two fill passes, line A first.
- clear during FILL sets abort. The outstanding word is still awaited: mem_req stays high until the next mem_done. Then go to IDLE with the line left invalid and abort cleared.
- clear in IDLE: no fill starts that cycle.
- rdy=0: no state, array, or counter changes. mem_req and mem_addr hold. An incoming mem_done is ignored; the memory controller is frozen by the same rdy.

## Timing
- Reset values: inst_ready_out=0, inst_out=0, mem_req=0, mem_addr=0, state=IDLE, cnt=0, abort=0, all valid=0.
- Hit: zero latency; inst_ready_out in the same cycle fetch_pc is presented.
- Miss, one line:
  - cycle 0: miss detected in IDLE
  - cycle 1: mem_req rises with mem_addr=base
  - after each mem_done, mem_addr advances the next cycle
  - the cycle after the 4th mem_done: IDLE, and inst_ready_out=1 if fetch_pc is unchanged
- mem_req stays high across consecutive words of a fill. It drops the cycle after the final (or abort-completing) mem_done.
- fetch_pc changing mid-fill does not cancel the fill; only clear aborts.
- rst mid-fill: everything returns to reset values next cycle. The memory controller is reset by the same rst.

## Structure
- Shared package:
  - LINE_OFF_BITS=4, LINE_WORDS=4
  - state enum {IDLE, FILL}
  - memory read-port request/response field widths, shared with the data-cache path
- One sub-module is natural: icache_array. It holds the valid/tag/data storage, with two combinational read ports (line A, line B) and one word write port.
- inst_cache keeps the FSM, half-word assembly, and hit logic.

## Test plan
- Cold miss at pc=0x0, memory word[0x0]=0x00000013:
  - mem_addr sequence 0x0, 0x4, 0x8, 0xC
  - the cycle after the 4th done, inst_out=0x00000013 and ready=1
  - then pc=0x4 hits the same cycle with no mem_req
- Intra-line unaligned: word[0x0]=0xBBBB_AAA3, word[0x4]=0xDDDD_CCCC, pc=0x2 → inst_out=0xCCCC_BBBB, no fill.
- Line straddle: line 0x0 resident, word[0xC]=0x4567_0001, line 0x10 absent, pc=0xE:
  - fill of 0x10–0x1C, with word[0x10]=0x89AB_CDEF
  - then inst_out=0xCDEF_4567
- Compressed at boundary: word[0xC]=0x4001_0000, line 0x10 absent, pc=0xE → same-cycle ready, inst_out=0x0000_4001, mem_req stays 0.
- Clear mid-fill: pc=0x100 miss, clear pulsed after the 2nd mem_done:
  - mem_req is held until the 3rd done, then drops
  - pc=0x100 afterwards misses again and refills from 0x100
- Conflict and freeze:
  - 0x000 then 0x100 (same index, INDEX_BITS=4) → the second fill evicts the first; re-access to 0x000 misses
  - rdy=0 for 3 cycles mid-fill → cnt and mem_addr unchanged
